// File: rtl/py_timer_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit limits,
// prescaler divide calculation and the packed digit layout.
package py_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int LIM_UNIT    = 9;
  localparam int LIM_TENS    = 5;
  localparam int LIM_H1      = 2;
  localparam int LIM_H0_TERM = 3;

  localparam int NUM_DIG = 8;
  localparam int NIB_W   = 4;
  localparam int DIG_W   = NUM_DIG * NIB_W;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/py_bcd_digit.sv
// One BCD counter cell: counts 0..MAX on en, wraps to 0, carry flags the wrap.
// clr has priority over en.
module py_bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] MAX_Q = 4'(MAX);

  logic [3:0] q_nx;

  assign carry = en && (q == MAX_Q);

  // q is reloaded every cycle so the held value always comes from q_nx
  always_comb begin
    q_nx = q;
    if (clr)
      q_nx = '0;
    else if (en)
      q_nx = (q == MAX_Q) ? 4'd0 : q + 4'd1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      q <= '0;
    else
      q <= q_nx;
  end

endmodule

// File: rtl/py_bcd_stopwatch.sv
// HH:MM:SS.cc stopwatch: prescaler, control FSM, BCD cascade, lap snapshot.
//   state | meaning
//   IDLE  | stopped and zeroed, waiting for start
//   RUN   | counting, display shows live value
//   PAUSE | counting halted, prescaler phase held
//   LAP   | counting, display frozen on snapshot
module py_bcd_stopwatch
  import py_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic        btn_clr,
  output logic [31:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);

  state_t           state;
  logic [PW-1:0]    presc;
  logic             tick;
  logic             clr_cnt;
  logic             hours_wrap;
  logic             clr_hours;
  logic [DIG_W-1:0] live;
  logic [DIG_W-1:0] snapshot;

  logic [3:0] q_c0, q_c1, q_s0, q_s1, q_m0, q_m1, q_h0, q_h1;
  logic       c_c0, c_c1, c_s0, c_s1, c_m0, c_m1, c_h0, c_h1;

  assign clr_cnt = (state == PAUSE) && btn_clr;
  assign tick    = ((state == RUN) || (state == LAP)) && (presc == PRESC_TC);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      presc <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= hours_wrap;
      if (clr_cnt)
        presc <= '0;
      else if ((state == RUN) || (state == LAP))
        presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Hours are a 0..29 pair; the 23 -> 00 terminal is detected here
  assign hours_wrap = (c_m1 && (q_h1 == 4'(LIM_H1)) && (q_h0 == 4'(LIM_H0_TERM))) || c_h1;
  assign clr_hours  = clr_cnt || hours_wrap;

  py_bcd_digit #(.MAX(LIM_UNIT)) u_c0 (.clk_in(clk_in), .rst(rst), .en(tick), .clr(clr_cnt), .q(q_c0), .carry(c_c0));
  py_bcd_digit #(.MAX(LIM_UNIT)) u_c1 (.clk_in(clk_in), .rst(rst), .en(c_c0), .clr(clr_cnt), .q(q_c1), .carry(c_c1));
  py_bcd_digit #(.MAX(LIM_UNIT)) u_s0 (.clk_in(clk_in), .rst(rst), .en(c_c1), .clr(clr_cnt), .q(q_s0), .carry(c_s0));
  py_bcd_digit #(.MAX(LIM_TENS)) u_s1 (.clk_in(clk_in), .rst(rst), .en(c_s0), .clr(clr_cnt), .q(q_s1), .carry(c_s1));
  py_bcd_digit #(.MAX(LIM_UNIT)) u_m0 (.clk_in(clk_in), .rst(rst), .en(c_s1), .clr(clr_cnt), .q(q_m0), .carry(c_m0));
  py_bcd_digit #(.MAX(LIM_TENS)) u_m1 (.clk_in(clk_in), .rst(rst), .en(c_m0), .clr(clr_cnt), .q(q_m1), .carry(c_m1));
  py_bcd_digit #(.MAX(LIM_UNIT)) u_h0 (.clk_in(clk_in), .rst(rst), .en(c_m1), .clr(clr_hours), .q(q_h0), .carry(c_h0));
  py_bcd_digit #(.MAX(LIM_H1))   u_h1 (.clk_in(clk_in), .rst(rst), .en(c_h0), .clr(clr_hours), .q(q_h1), .carry(c_h1));

  assign live   = {q_h1, q_h0, q_m1, q_m0, q_s1, q_s0, q_c1, q_c0};
  assign digits = lap_active ? snapshot : live;

  // clr outranks ss outranks lap; states that ignore an input fall through
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      snapshot   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_ss) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (btn_ss) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (btn_lap) begin
            state      <= LAP;
            lap_active <= 1'b1;
            snapshot   <= live;
          end
        end
        PAUSE: begin
          if (btn_clr) begin
            state <= IDLE;
          end else if (btn_ss) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        LAP: begin
          if (btn_ss) begin
            state      <= PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (btn_lap) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_py_bcd_stopwatch.sv
// Stopwatch bench: directed button sequences push expected outputs into a
// scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_py_bcd_stopwatch;

   logic        clk_in;
   logic        rst;
   logic        btn_ss;
   logic        btn_lap;
   logic        btn_clr;
   logic [31:0] digits;
   logic        running;
   logic        lap_active;
   logic        wrap;

   typedef struct packed {
      logic [31:0] digits;
      logic        running;
      logic        lap;
      logic        wrap;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   exp_t  mon_e;
   string mon_n;
   int    total;
   int    bad;

   py_bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(10)) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .btn_ss     (btn_ss),
      .btn_lap    (btn_lap),
      .btn_clr    (btn_clr),
      .digits     (digits),
      .running    (running),
      .lap_active (lap_active),
      .wrap       (wrap)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      total = 0;
      bad   = 0;
   end

   always @(negedge clk_in) begin
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_n = name_q.pop_front();
         total = total + 1;
         if (digits !== mon_e.digits || running !== mon_e.running ||
             lap_active !== mon_e.lap || wrap !== mon_e.wrap) begin
            bad = bad + 1;
            $display("FAIL %s: got digits=%h running=%b lap_active=%b wrap=%b, want digits=%h running=%b lap_active=%b wrap=%b",
                     mon_n, digits, running, lap_active, wrap,
                     mon_e.digits, mon_e.running, mon_e.lap, mon_e.wrap);
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] d, input logic r, input logic l, input logic w);
      exp_t e;
      e.digits  = d;
      e.running = r;
      e.lap     = l;
      e.wrap    = w;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic press(input logic ss, input logic lap, input logic clr);
      btn_ss  = ss;
      btn_lap = lap;
      btn_clr = clr;
      @(posedge clk_in);
      #1;
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
      btn_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
      btn_clr = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      rst = 1'b0;
      wait_cyc(50);
      chk("reset_idle", 32'h0, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      chk("idle_lap_ignored", 32'h0, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      chk("idle_clr_noop", 32'h0, 1'b0, 1'b0, 1'b0);

      // start: first tick lands ten edges after the start edge
      press(1'b1, 1'b0, 1'b0);
      wait_cyc(5);
      chk("run_5", 32'h0, 1'b1, 1'b0, 1'b0);
      wait_cyc(5);
      chk("run_10", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      wait_cyc(90);
      chk("run_100", 32'h0000_0010, 1'b1, 1'b0, 1'b0);
      wait_cyc(270);
      chk("run_037", 32'h0000_0037, 1'b1, 1'b0, 1'b0);

      press(1'b0, 1'b1, 1'b0);
      chk("lap_enter", 32'h0000_0037, 1'b1, 1'b1, 1'b0);
      wait_cyc(50);
      chk("lap_hold", 32'h0000_0037, 1'b1, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      chk("lap_release", 32'h0000_0042, 1'b1, 1'b0, 1'b0);

      press(1'b1, 1'b0, 1'b0);
      wait_cyc(30);
      chk("pause_hold_042", 32'h0000_0042, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      chk("pause_clr", 32'h0, 1'b0, 1'b0, 1'b0);

      // pause at 0.05 with prescaler phase 1, resume must keep that phase
      press(1'b1, 1'b0, 1'b0);
      wait_cyc(50);
      chk("run_005", 32'h0000_0005, 1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      wait_cyc(30);
      chk("pause_005", 32'h0000_0005, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      wait_cyc(8);
      chk("resume_8", 32'h0000_0005, 1'b1, 1'b0, 1'b0);
      wait_cyc(1);
      chk("resume_9", 32'h0000_0006, 1'b1, 1'b0, 1'b0);

      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b1);
      chk("clr_ss_pause", 32'h0, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      wait_cyc(9);
      chk("presc_zero_9", 32'h0, 1'b1, 1'b0, 1'b0);
      wait_cyc(1);
      chk("presc_zero_10", 32'h0000_0001, 1'b1, 1'b0, 1'b0);

      press(1'b0, 1'b0, 1'b1);
      chk("run_clr_ignored", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      chk("lap_ss_pause", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      chk("clr_after_lap", 32'h0, 1'b0, 1'b0, 1'b0);

      // rollover: preload 23:59:59.99 while paused with prescaler phase 1
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      wait_cyc(1);
      force dut.u_c0.q = 4'd9;
      force dut.u_c1.q = 4'd9;
      force dut.u_s0.q = 4'd9;
      force dut.u_s1.q = 4'd5;
      force dut.u_m0.q = 4'd9;
      force dut.u_m1.q = 4'd5;
      force dut.u_h0.q = 4'd3;
      force dut.u_h1.q = 4'd2;
      wait_cyc(2);
      release dut.u_c0.q;
      release dut.u_c1.q;
      release dut.u_s0.q;
      release dut.u_s1.q;
      release dut.u_m0.q;
      release dut.u_m1.q;
      release dut.u_h0.q;
      release dut.u_h1.q;
      chk("preload_max", 32'h2359_5999, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      wait_cyc(8);
      chk("pre_wrap", 32'h2359_5999, 1'b1, 1'b0, 1'b0);
      wait_cyc(1);
      chk("wrap_pulse", 32'h0, 1'b1, 1'b0, 1'b1);
      wait_cyc(1);
      chk("wrap_one_cycle", 32'h0, 1'b1, 1'b0, 1'b0);
      wait_cyc(8);
      chk("post_wrap_9", 32'h0, 1'b1, 1'b0, 1'b0);
      wait_cyc(1);
      chk("post_wrap_10", 32'h0000_0001, 1'b1, 1'b0, 1'b0);

      // async reset mid-run: outputs must clear before the next edge
      wait_cyc(25);
      chk("pre_rst_run", 32'h0000_0003, 1'b1, 1'b0, 1'b0);
      wait_cyc(1);
      rst = 1'b1;
      #1;
      chk("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(20);
      chk("post_rst_idle", 32'h0, 1'b0, 1'b0, 1'b0);

      wait_cyc(2);
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard: %0d expectations never compared", exp_q.size());
         bad = bad + 1;
      end
      if (total < 12) begin
         $display("FAIL coverage: only %0d comparisons made", total);
         bad = bad + 1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      if (bad != 0) begin
         $display("FAIL: %0d mismatches", bad);
         $fatal(1);
      end else begin
         $display("PASS");
      end
      $finish;
   end

endmodule
